spi_master_fifo: RTL and testbench

// - Synchronous FIFO between the SPI APB register interface and the SPI controller.
// - Instantiated twice:
//   - TX path: APB writes to REG_TXFIFO push words; the controller pops them.
//   - RX path: the controller pushes received words; APB reads of REG_RXFIFO pop them.
// - elements_o feeds the interrupt threshold compare (spi_int_th_tx/rx) and the status fields.

---
 rtl/spi_master_fifo.sv | 79 +++++++
 tb/tb_spi_master_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fifo.sv
// Synchronous word FIFO between the SPI APB registers and the SPI controller.
// Optional same-cycle fall-through on an empty FIFO: define SPI_FIFO_FALLTHROUGH_EN.
module spi_master_fifo #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_DEPTH     = 10,
  parameter int unsigned LOG_BUFFER_DEPTH = 4
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        clr_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam int unsigned PTR_W = LOG_BUFFER_DEPTH;
  localparam int unsigned CNT_W = LOG_BUFFER_DEPTH + 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  push, pop;
  logic                  push_store, pop_store;

  assign empty      = (count == '0);
  assign ready_o    = (count != CNT_FULL);
  assign elements_o = count;
  assign push       = valid_i & ready_o;
  assign pop        = valid_o & ready_i;

`ifdef SPI_FIFO_FALLTHROUGH_EN
  // An empty FIFO presents the incoming word directly; if consumed at once it is never stored.
  logic bypass;
  assign valid_o    = ~empty | valid_i;
  assign data_o     = empty ? data_i : mem[rd_ptr];
  assign bypass     = empty & valid_i & ready_i;
  assign push_store = push & ~bypass;
  assign pop_store  = pop & ~bypass;
`else
  assign valid_o    = ~empty;
  assign data_o     = mem[rd_ptr];
  assign push_store = push;
  assign pop_store  = pop;
`endif

  // Pointer and occupancy state; clr_i flushes and overrides any handshake.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_store) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_store)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_store, pop_store})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge HCLK) begin
    if (push_store && !clr_i) mem[wr_ptr] <= data_i;
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed self-checking bench for spi_master_fifo (default 32x10 configuration).
module tb_spi_master_fifo;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        clr_i;
  logic [4:0]  elements_o;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

  int checks = 0;
  int errors = 0;

  spi_master_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(10), .LOG_BUFFER_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .clr_i(clr_i), .elements_o(elements_o),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_i = base + 32'(i);
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic drain_n(input string tag, input int n, input logic [31:0] base);
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 32'(valid_o), 32'd1);
      check({tag, "_data"}, data_o, base + 32'(i));
      tick();
    end
    ready_i = 1'b0;
    check({tag, "_empty"}, 32'(valid_o), 32'd0);
    check({tag, "_cnt0"}, 32'(elements_o), 32'd0);
  endtask

  initial begin
    HRESETn = 1'b0;
    clr_i   = 1'b0;
    data_i  = '0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #12;
    check("rst_elements", 32'(elements_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    HRESETn = 1'b1;
    tick();

    // Fill to full, then an 11th push is held off.
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("fill_ready", 32'(ready_o), 32'd1);
      data_i = 32'hA0 + 32'(i);
      tick();
      check("fill_cnt", 32'(elements_o), 32'(i + 1));
    end
    check("full_ready", 32'(ready_o), 32'd0);
    data_i = 32'hAA;
    tick();
    check("full_hold_cnt", 32'(elements_o), 32'd10);
    valid_i = 1'b0;
    drain_n("drain", 10, 32'hA0);

    // Simultaneous push/pop at count 5.
    push_n(5, 32'hB0);
    check("sim_start_cnt", 32'(elements_o), 32'd5);
    valid_i = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_i = 32'hB5 + 32'(i);
      check("sim_data", data_o, 32'hB0 + 32'(i));
      tick();
      check("sim_cnt", 32'(elements_o), 32'd5);
    end
    drain_n("sim_drain", 5, 32'hB8);

    // Wrap: 25 push/pop pairs with 3 words resident.
    push_n(3, 32'h100);
    valid_i = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 25; i++) begin
      data_i = 32'h103 + 32'(i);
      check("wrap_data", data_o, 32'h100 + 32'(i));
      tick();
      check("wrap_cnt", 32'(elements_o), 32'd3);
    end
    drain_n("wrap_drain", 3, 32'h119);

    // Full with simultaneous push and pop.
    push_n(10, 32'hE0);
    valid_i = 1'b1;
    ready_i = 1'b1;
    data_i  = 32'hEA;
    check("fp_ready", 32'(ready_o), 32'd0);
    check("fp_head", data_o, 32'hE0);
    tick();
    check("fp_cnt9", 32'(elements_o), 32'd9);
    check("fp_ready9", 32'(ready_o), 32'd1);
    ready_i = 1'b0;
    tick();
    check("fp_cnt10", 32'(elements_o), 32'd10);
    drain_n("fp_drain", 10, 32'hE1);

    // Flush at count 6 with a simultaneous push.
    push_n(6, 32'hC0);
    clr_i   = 1'b1;
    valid_i = 1'b1;
    data_i  = 32'hCF;
    check("clr_ready_ungated", 32'(ready_o), 32'd1);
    check("clr_valid_ungated", 32'(valid_o), 32'd1);
    tick();
    clr_i   = 1'b0;
    valid_i = 1'b0;
    check("clr_cnt", 32'(elements_o), 32'd0);
    check("clr_valid", 32'(valid_o), 32'd0);
    push_n(1, 32'hF0);
    drain_n("clr_after", 1, 32'hF0);

    // Asynchronous reset mid-stream.
    push_n(4, 32'h70);
    HRESETn = 1'b0;
    #1;
    check("arst_cnt", 32'(elements_o), 32'd0);
    check("arst_ready", 32'(ready_o), 32'd1);
    check("arst_valid", 32'(valid_o), 32'd0);
    #1;
    HRESETn = 1'b1;
    tick();
    push_n(2, 32'h80);
    drain_n("arst_after", 2, 32'h80);

    // Empty-FIFO latency.
    valid_i = 1'b1;
    ready_i = 1'b1;
    data_i  = 32'h5A;
`ifdef SPI_FIFO_FALLTHROUGH_EN
    #1;
    check("ft_valid", 32'(valid_o), 32'd1);
    check("ft_data", data_o, 32'h5A);
    tick();
    valid_i = 1'b0;
    ready_i = 1'b0;
    check("ft_cnt", 32'(elements_o), 32'd0);
    check("ft_valid_after", 32'(valid_o), 32'd0);
`else
    #1;
    check("lat_valid0", 32'(valid_o), 32'd0);
    tick();
    valid_i = 1'b0;
    check("lat_cnt1", 32'(elements_o), 32'd1);
    check("lat_valid1", 32'(valid_o), 32'd1);
    check("lat_data", data_o, 32'h5A);
    tick();
    ready_i = 1'b0;
    check("lat_cnt0", 32'(elements_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
